convolver: RTL and testbench



---
 rtl/convolver.sv | 129 ++++++++++++
 tb/tb_convolver.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/convolver.sv
// -----------------------------------------------------------------------------
// convolver
//   Streaming 2D valid-mode convolution (correlation) engine. Consumes one
//   pixel of an INPUT_SIZE x INPUT_SIZE map per enabled clock in raster order.
//   For every window position on the STRIDE grid it presents
//   sum(kernel * window) + bias, with no added latency, on the cycle after the
//   edge that captured the window's bottom-right pixel.
//
// Ports
//   clk         clock, all state updates on the rising edge
//   global_rst  asynchronous active-high reset
//   ce          clock enable; every high cycle consumes one pixel
//   myInput     current input pixel (signed)
//   weight      packed kernel, weight[(kr*K+kc)*DATA_WIDTH +: DATA_WIDTH]
//   bias        signed bias added to every output
//   conv_op     window result, low DATA_WIDTH bits of the sum (0 when not valid)
//   valid_conv  conv_op holds a window result this cycle
//   end_conv    whole frame processed (sticky until global_rst)
// -----------------------------------------------------------------------------
module convolver #(
  parameter int DATA_WIDTH  = 8,
  parameter int INPUT_SIZE  = 28,
  parameter int KERNEL_SIZE = 3,
  parameter int STRIDE      = 1
) (
  input  logic                                              clk,
  input  logic                                              global_rst,
  input  logic                                              ce,
  input  logic signed [DATA_WIDTH-1:0]                      myInput,
  input  logic        [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] weight,
  input  logic signed [DATA_WIDTH-1:0]                      bias,
  output logic signed [DATA_WIDTH-1:0]                      conv_op,
  output logic                                              valid_conv,
  output logic                                              end_conv
);

  localparam int N       = INPUT_SIZE;
  localparam int K       = KERNEL_SIZE;
  localparam int S       = STRIDE;
  // Enough history to reach from the newest pixel back to the window's
  // top-left corner.
  localparam int BUF_LEN = (K - 1) * N + K;
  localparam int PW      = 2 * DATA_WIDTH;
  localparam int ACC_W   = PW + $clog2(K * K) + 1;
  localparam int CNT_W   = $clog2(N + 1);

  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(N - 1);
  // The row counter only reaches N after the frame's last pixel is captured.
  localparam logic [CNT_W-1:0] ROW_DONE = CNT_W'(N);

  // win[0] is the newest pixel; win[BUF_LEN-1] the oldest still needed.
  logic signed [DATA_WIDTH-1:0] win [BUF_LEN];
  logic        [CNT_W-1:0]      row;
  logic        [CNT_W-1:0]      col;
  logic                         win_flag;
  logic                         cap_hit;
  logic                         advance;
  logic                         frame_done;
  logic signed [PW-1:0]         prod;
  logic signed [ACC_W-1:0]      acc;
  logic                         unused_acc_hi;

  assign advance    = ce & ~end_conv;
  assign frame_done = (row == ROW_DONE);

  // Does the pixel about to be captured, at (row, col), complete a window
  // that lies on the stride grid?  Windows with col < K-1 would straddle a
  // row wrap and are excluded.
  always_comb begin
    // NOTE: every always_comb output gets a default first, otherwise a path
    // that skips the assignment infers a latch.
    cap_hit = 1'b0;
    if (int'(row) >= K - 1 && int'(col) >= K - 1)
      cap_hit = ((int'(row) - (K - 1)) % S == 0) &&
                ((int'(col) - (K - 1)) % S == 0);
  end

  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      // NOTE: the line buffer is a shift register in flops, not a RAM, so it
      // takes the reset like any other state and a new frame starts from 0.
      for (int i = 0; i < BUF_LEN; i++) win[i] <= '0;
      row      <= '0;
      col      <= '0;
      win_flag <= 1'b0;
      end_conv <= 1'b0;
    end else if (advance) begin
      if (frame_done) begin
        // The enabled cycle after the last capture presents the final
        // window; its closing edge retires the frame.
        end_conv <= 1'b1;
        win_flag <= 1'b0;
      end else begin
        // NOTE: non-blocking assignments make every win[i] take its
        // neighbour's pre-edge value, giving a true shift in any loop order.
        win[0] <= myInput;
        for (int i = 1; i < BUF_LEN; i++) win[i] <= win[i-1];
        win_flag <= cap_hit;
        if (col == COL_LAST) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // Window pixel (kr, kc) sits (K-1-kr)*N + (K-1-kc) places behind the newest.
  always_comb begin
    acc  = ACC_W'(bias);
    prod = '0;
    for (int kr = 0; kr < K; kr++) begin
      for (int kc = 0; kc < K; kc++) begin
        prod = PW'(win[(K - 1 - kr) * N + (K - 1 - kc)]) *
               PW'($signed(weight[(kr * K + kc) * DATA_WIDTH +: DATA_WIDTH]));
        acc  = acc + ACC_W'(prod);
      end
    end
  end

  // The result wraps to DATA_WIDTH bits; the upper accumulator bits are
  // deliberately dropped.
  assign unused_acc_hi = ^acc[ACC_W-1:DATA_WIDTH];

  assign valid_conv = win_flag & ce;
  assign conv_op    = valid_conv ? acc[DATA_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_convolver.sv
// -----------------------------------------------------------------------------
// tb_convolver
//   Directed bench for convolver. Three instances cover the parameter sets
//   used: dut_a (N=4,K=3,S=1), dut_b (N=28,K=3,S=1), dut_c (N=5,K=3,S=2).
//   They share clock, reset, pixel, weight and bias; sel picks which one
//   receives ce and which one's outputs are observed.
// -----------------------------------------------------------------------------
module tb_convolver;

  logic              clk = 1'b0;
  logic              rst;
  logic              ce;
  logic [1:0]        sel;
  logic signed [7:0] pix;
  logic signed [7:0] bias;
  logic [71:0]       weight;

  logic              ce_a, ce_b, ce_c;
  logic signed [7:0] op_a, op_b, op_c;
  logic              v_a, v_b, v_c;
  logic              e_a, e_b, e_c;
  logic [7:0]        obs_op;
  logic              obs_valid;
  logic              obs_end;

  int          n_checks = 0;
  int          n_err    = 0;
  int          cap_cnt;
  int          got_idx[$];
  int          exp_idx[$];
  logic [7:0]  got_val[$];
  logic [7:0]  exp_val[$];
  int          img_v[25];
  int          w_v[9];

  always #5 clk = ~clk;

  assign ce_a = ce && (sel == 2'd0);
  assign ce_b = ce && (sel == 2'd1);
  assign ce_c = ce && (sel == 2'd2);

  convolver #(.DATA_WIDTH(8), .INPUT_SIZE(4), .KERNEL_SIZE(3), .STRIDE(1)) dut_a (
    .clk(clk), .global_rst(rst), .ce(ce_a), .myInput(pix), .weight(weight),
    .bias(bias), .conv_op(op_a), .valid_conv(v_a), .end_conv(e_a));

  convolver #(.DATA_WIDTH(8), .INPUT_SIZE(28), .KERNEL_SIZE(3), .STRIDE(1)) dut_b (
    .clk(clk), .global_rst(rst), .ce(ce_b), .myInput(pix), .weight(weight),
    .bias(bias), .conv_op(op_b), .valid_conv(v_b), .end_conv(e_b));

  convolver #(.DATA_WIDTH(8), .INPUT_SIZE(5), .KERNEL_SIZE(3), .STRIDE(2)) dut_c (
    .clk(clk), .global_rst(rst), .ce(ce_c), .myInput(pix), .weight(weight),
    .bias(bias), .conv_op(op_c), .valid_conv(v_c), .end_conv(e_c));

  always_comb begin
    obs_op    = op_a;
    obs_valid = v_a;
    obs_end   = e_a;
    if (sel == 2'd1) begin
      obs_op = op_b; obs_valid = v_b; obs_end = e_b;
    end else if (sel == 2'd2) begin
      obs_op = op_c; obs_valid = v_c; obs_end = e_c;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, sample 2 ns later (well before the
  // rising edge), log any valid output against the index of the last pixel
  // captured so far.
  task automatic step(input logic c, input logic [7:0] p);
    @(negedge clk);
    ce  = c;
    pix = p;
    #2;
    if (obs_valid) begin
      got_idx.push_back(cap_cnt - 1);
      got_val.push_back(obs_op);
    end
    if (c && !obs_end) cap_cnt++;
  endtask

  task automatic begin_frame(input logic [1:0] s);
    @(negedge clk);
    sel     = s;
    ce      = 1'b0;
    cap_cnt = 0;
    got_idx.delete();
    got_val.delete();
    exp_idx.delete();
    exp_val.delete();
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    ce  = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_all_weights(input logic [7:0] w);
    for (int i = 0; i < 9; i++) weight[i*8 +: 8] = w;
  endtask

  task automatic compare_outputs(input string tag);
    check({tag, " count"}, got_idx.size(), exp_idx.size());
    for (int i = 0; i < exp_idx.size() && i < got_idx.size(); i++) begin
      check($sformatf("%s idx[%0d]", tag, i), got_idx[i], exp_idx[i]);
      check($sformatf("%s val[%0d]", tag, i), got_val[i], exp_val[i]);
    end
  endtask

  task automatic expect_out(input int idx, input logic [7:0] val);
    exp_idx.push_back(idx);
    exp_val.push_back(val);
  endtask

  initial begin
    rst    = 1'b1;
    ce     = 1'b0;
    sel    = 2'd0;
    pix    = '0;
    bias   = '0;
    weight = '0;
    cap_cnt = 0;
    #12;

    // Reset state of every instance.
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      check($sformatf("reset valid dut%0d", s), obs_valid, 1'b0);
      check($sformatf("reset op dut%0d", s), obs_op, 8'd0);
      check($sformatf("reset end dut%0d", s), obs_end, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;

    // 1: N=4 all ones -> four outputs of 9 after pixels 10, 11, 14, 15.
    begin_frame(2'd0);
    set_all_weights(8'd1);
    bias = 8'sd0;
    for (int i = 0; i < 16; i++) step(1'b1, 8'd1);
    step(1'b1, 8'd0);
    check("t1 last window end low", obs_end, 1'b0);
    check("t1 last window valid", obs_valid, 1'b1);
    for (int i = 0; i < 4; i++) expect_out((i < 2) ? 10 + i : 12 + i, 8'd9);
    compare_outputs("t1");
    @(negedge clk);
    #1;
    check("t1 end after frame", obs_end, 1'b1);
    step(1'b1, 8'd5);
    check("t1 ignored valid", obs_valid, 1'b0);
    check("t1 ignored op", obs_op, 8'd0);
    check("t1 end sticky", obs_end, 1'b1);

    // end_conv clears on reset.
    @(negedge clk);
    ce  = 1'b0;
    rst = 1'b1;
    #1;
    check("t6 end cleared", obs_end, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // 6a: reset mid-frame while a window is being presented.
    begin_frame(2'd0);
    for (int i = 0; i < 11; i++) step(1'b1, 8'(i + 1));
    step(1'b1, 8'd12);
    check("t6 pre-reset valid", obs_valid, 1'b1);
    check("t6 pre-reset op", obs_op, 8'd54);
    rst = 1'b1;
    #1;
    check("t6 reset valid", obs_valid, 1'b0);
    check("t6 reset op", obs_op, 8'd0);
    @(negedge clk);
    ce  = 1'b0;
    rst = 1'b0;

    // 5: ramp 1..16, ones kernel, 3-cycle stall after pixel 11.
    // Window sums are 9x the centre: 54, 63, 90, 99.
    begin_frame(2'd0);
    for (int i = 0; i < 12; i++) step(1'b1, 8'(i + 1));
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h55);
      check($sformatf("t5 stall valid %0d", i), obs_valid, 1'b0);
      check($sformatf("t5 stall op %0d", i), obs_op, 8'd0);
    end
    for (int i = 12; i < 16; i++) step(1'b1, 8'(i + 1));
    step(1'b1, 8'd0);
    expect_out(10, 8'd54);
    expect_out(11, 8'd63);
    expect_out(14, 8'd90);
    expect_out(15, 8'd99);
    compare_outputs("t5");
    pulse_reset();

    // 4: overflow wraps: 9*127*127 + 127 = 145288 = 0x23788 -> 0x88.
    begin_frame(2'd0);
    set_all_weights(8'd127);
    bias = 8'sd127;
    for (int i = 0; i < 16; i++) step(1'b1, 8'd127);
    step(1'b1, 8'd0);
    for (int i = 0; i < 4; i++) expect_out((i < 2) ? 10 + i : 12 + i, 8'h88);
    compare_outputs("t4");
    pulse_reset();

    // 6b: 20 pixels into dut_b, then reset.
    begin_frame(2'd1);
    set_all_weights(8'd0);
    weight[4*8 +: 8] = 8'd1;
    bias = 8'sd0;
    for (int i = 0; i < 20; i++) step(1'b1, 8'(i + 100));
    pulse_reset();
    #1;
    check("t6 dut_b end after reset", obs_end, 1'b0);
    check("t6 dut_b valid after reset", obs_valid, 1'b0);

    // 2: N=28 ramp through identity kernel -> every output is the centre pixel.
    begin_frame(2'd1);
    for (int i = 0; i < 784; i++) step(1'b1, 8'(i % 256));
    step(1'b1, 8'd0);
    for (int r = 2; r < 28; r++)
      for (int c = 2; c < 28; c++)
        expect_out(r * 28 + c, 8'(((r - 1) * 28 + (c - 1)) % 256));
    compare_outputs("t2");
    @(negedge clk);
    #1;
    check("t2 end after frame", obs_end, 1'b1);
    pulse_reset();

    // 3: N=5, S=2, mixed-sign data, bias -3 -> windows ending at
    // (2,2), (2,4), (4,2), (4,4).
    begin_frame(2'd2);
    for (int i = 0; i < 25; i++) img_v[i] = ((i * 37 + 11) % 256) - 128;
    for (int i = 0; i < 9; i++) begin
      w_v[i] = ((i * 53 + 7) % 256) - 128;
      weight[i*8 +: 8] = 8'(w_v[i]);
    end
    bias = -8'sd3;
    for (int i = 0; i < 25; i++) step(1'b1, 8'(img_v[i]));
    step(1'b1, 8'd0);
    for (int r = 2; r < 5; r += 2) begin
      for (int c = 2; c < 5; c += 2) begin
        int sum;
        sum = -3;
        for (int kr = 0; kr < 3; kr++)
          for (int kc = 0; kc < 3; kc++)
            sum += img_v[(r - 2 + kr) * 5 + (c - 2 + kc)] * w_v[kr * 3 + kc];
        expect_out(r * 5 + c, sum[7:0]);
      end
    end
    compare_outputs("t3");
    @(negedge clk);
    #1;
    check("t3 end after frame", obs_end, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
